// File: rtl/seq_mult_adder.sv
// seq_mult_adder: chunk-serial signed dot-product with accumulate, D = C_in + sum(row[k]*column[k]).
module seq_mult_adder #(
    parameter int K         = 1,
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic signed [K-1:0][MAX_WIDTH-1:0] row,
    input  logic signed [K-1:0][MAX_WIDTH-1:0] column,
    input  logic signed [31:0]                 C_in,
    input  logic        [4:0]                  bitSizeA,
    input  logic        [4:0]                  bitSizeB,
    input  logic                               valid_in,
    output logic                               ready_in,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic signed [31:0]                 D
);
    localparam logic [4:0] MAX_CH = 5'(MAX_WIDTH / P);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                     r_state, w_next;
    logic [K-1:0][MAX_WIDTH-1:0] r_row, r_col;
    logic [4:0]                 r_na, r_nb, r_i, r_j;
    logic signed [31:0]         r_acc, r_d, w_sum;
    logic signed [2*P+1:0]      w_pp;
    logic [7:0]                 w_sh;
    logic                       w_last, w_accept;

    function automatic logic [4:0] clamp(input logic [4:0] n);
        return (n == '0) ? 5'd1 : ((n > MAX_CH) ? MAX_CH : n);
    endfunction

    // Only the top chunk of an operand carries the sign; lower chunks are magnitude bits.
    function automatic logic signed [P:0] chunk(input logic [MAX_WIDTH-1:0] v, input logic [4:0] c, input logic [4:0] n);
        logic [P-1:0] w_bits;
        w_bits = P'(v >> (P * c));
        return (c == n - 5'd1) ? {w_bits[P-1], w_bits} : {1'b0, w_bits};
    endfunction

    assign w_accept  = (r_state == IDLE) && valid_in;
    assign w_last    = (r_i == r_na - 5'd1) && (r_j == r_nb - 5'd1);
    assign ready_in  = (r_state == IDLE);
    assign valid_out = (r_state == DONE);
    assign D         = r_d;

    always_comb begin
        w_sum = '0;
        w_pp  = '0;
        w_sh  = 8'(P) * (8'(r_i) + 8'(r_j));
        for (int k = 0; k < K; k++) begin
            w_pp  = chunk(r_row[k], r_i, r_na) * chunk(r_col[k], r_j, r_nb);
            w_sum = w_sum + (32'(w_pp) << w_sh);
        end
    end

    always_comb begin
        w_next = r_state;
        w_next = w_accept ? BUSY
               : (r_state == BUSY && w_last) ? DONE
               : (r_state == DONE && ready_out) ? IDLE
               : r_state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_na    <= 5'd1;
            r_nb    <= 5'd1;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_row <= row;
                r_col <= column;
                r_na  <= clamp(bitSizeA);
                r_nb  <= clamp(bitSizeB);
                r_i   <= '0;
                r_j   <= '0;
                r_acc <= C_in;
            end else if (r_state == BUSY) begin
                r_acc <= r_acc + w_sum;
                r_j   <= (r_j == r_nb - 5'd1) ? '0 : r_j + 5'd1;
                r_i   <= (r_j == r_nb - 5'd1) ? r_i + 5'd1 : r_i;
                if (w_last)
                    r_d <= r_acc + w_sum;
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_adder.sv
// tb_seq_mult_adder: random and directed checks of seq_mult_adder against an integer-arithmetic model.
module tb_seq_mult_adder;
    localparam int K  = 1;
    localparam int P  = 2;
    localparam int MW = 16;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic signed [K-1:0][MW-1:0] row, column;
    logic signed [31:0]          C_in, D;
    logic [4:0]                  bitSizeA, bitSizeB;
    logic                        valid_in, ready_in, valid_out, ready_out;
    int                          checks = 0;
    int                          failures = 0;

    always #5 clk_i = ~clk_i;

    seq_mult_adder #(.K(K), .P(P), .MAX_WIDTH(MW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .row(row), .column(column), .C_in(C_in),
        .bitSizeA(bitSizeA), .bitSizeB(bitSizeB), .valid_in(valid_in), .ready_in(ready_in),
        .valid_out(valid_out), .ready_out(ready_out), .D(D)
    );

    function automatic int eff(input logic [4:0] n);
        return (n == 0) ? 1 : ((n > 8) ? 8 : int'(n));
    endfunction

    // Operand value is the low P*N bits read as a two's-complement number.
    function automatic longint sval(input logic [15:0] v, input logic [4:0] n);
        int w;
        longint x;
        w = P * eff(n);
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (x >= (longint'(1) << (w - 1))) x -= longint'(1) << w;
        return x;
    endfunction

    function automatic logic [31:0] model(input logic [15:0] a, b, input logic [31:0] c, input logic [4:0] na, nb);
        return 32'(longint'(signed'(c)) + sval(a, na) * sval(b, nb));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [15:0] a, b, input logic [31:0] c, input logic [4:0] na, nb,
                      input logic [31:0] exp, input int hold, input bit stream);
        int cyc;
        row[0] = a; column[0] = b; C_in = c; bitSizeA = na; bitSizeB = nb;
        valid_in = 1'b1;
        ready_out = (hold == 0);
        if (!stream) check("ready_in_idle", 32'(ready_in), 32'd1);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
            if (!stream && cyc == 1) begin
                check("ready_in_busy", 32'(ready_in), 32'd0);
                valid_in = 1'b0;
                row[0] = 16'($urandom); column[0] = 16'($urandom); C_in = $urandom;
                bitSizeA = 5'($urandom); bitSizeB = 5'($urandom);
            end
        end while (!valid_out && cyc < 300);
        check("valid_out_timeout", 32'(valid_out), 32'd1);
        if (!stream) check("latency", 32'(cyc), 32'(eff(na) * eff(nb) + 1));
        check("D", D, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            check("hold_valid", 32'(valid_out), 32'd1);
            check("hold_D", D, exp);
            check("hold_ready_in", 32'(ready_in), 32'd0);
        end
        ready_out = 1'b1;
        if (!stream) begin
            @(negedge clk_i);
            check("valid_out_drop", 32'(valid_out), 32'd0);
            check("ready_in_back", 32'(ready_in), 32'd1);
            check("D_retained", D, exp);
        end
    endtask

    initial begin
        logic [15:0] a, b;
        logic [31:0] c;
        logic [4:0]  na, nb;
        row = '0; column = '0; C_in = '0; bitSizeA = 5'd1; bitSizeB = 5'd1;
        valid_in = 1'b0; ready_out = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_D", D, 32'd0);
        @(negedge clk_i);

        op(16'h0002, 16'h0001, 32'd0, 5'd1, 5'd1, -32'sd2, 0, 1'b0);
        op(16'h0080, 16'h007F, 32'd0, 5'd4, 5'd4, -32'sd16256, 0, 1'b0);
        op(16'h2000, 16'h2000, 32'd0, 5'd7, 5'd7, 32'h0400_0000, 0, 1'b0);
        op(16'h0007, 16'h0800, 32'd100, 5'd2, 5'd6, -32'sd14236, 0, 1'b0);
        op(16'hFFF1, 16'hABC3, 32'd0, 5'd2, 5'd2, 32'd3, 5, 1'b0);
        op(16'h8000, 16'h8000, 32'd0, 5'd8, 5'd8, 32'h4000_0000, 0, 1'b0);
        op(16'h8000, 16'h8000, 32'd0, 5'd31, 5'd20, 32'h4000_0000, 0, 1'b0);
        op(16'h0003, 16'h0002, 32'd5, 5'd0, 5'd0, 32'd7, 0, 1'b0);
        op(16'h0001, 16'h0001, 32'h7FFF_FFFF, 5'd1, 5'd1, 32'h8000_0000, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            a = 16'($urandom); b = 16'($urandom); c = $urandom;
            na = 5'($urandom_range(0, 31)); nb = 5'($urandom_range(0, 31));
            op(a, b, c, na, nb, model(a, b, c, na, nb), 0, 1'b0);
        end

        for (int x = 1; x <= 7; x++) begin
            for (int y = 1; y <= 7; y++) begin
                a = 16'($urandom); b = 16'($urandom); c = $urandom;
                op(a, b, c, 5'(x), 5'(y), model(a, b, c, 5'(x), 5'(y)), 0, 1'b1);
            end
        end
        valid_in = 1'b0;
        repeat (2) @(negedge clk_i);

        row[0] = 16'h1234; column[0] = 16'h5678; C_in = 32'd9;
        bitSizeA = 5'd4; bitSizeB = 5'd4; valid_in = 1'b1;
        @(negedge clk_i);
        valid_in = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_D", D, 32'd0);
        check("midrst_ready_in", 32'(ready_in), 32'd1);
        repeat (20) @(negedge clk_i);
        check("midrst_no_result", 32'(valid_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
